// File: rtl/fifo_writectrl_if.sv
// Flit link from upstream plus the shared write port of the regular/priority FIFO pair.
// The write controller uses the slave view; the environment that drives flits and owns the FIFOs uses master.
interface fifo_writectrl_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic [2:0]        in_head;
  logic              in_pri;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;

  logic              regularFIFO_full;
  logic              priorityFIFO_full;
  logic              regularFIFO_write;
  logic              priorityFIFO_write;
  logic [2:0]        fifo_whead;
  logic [DATA_W-1:0] fifo_wdata;

  modport master (
    output in_valid, in_head, in_pri, in_data,
    output regularFIFO_full, priorityFIFO_full,
    input  in_ready,
    input  regularFIFO_write, priorityFIFO_write, fifo_whead, fifo_wdata
  );

  modport slave (
    input  in_valid, in_head, in_pri, in_data,
    input  regularFIFO_full, priorityFIFO_full,
    output in_ready,
    output regularFIFO_write, priorityFIFO_write, fifo_whead, fifo_wdata
  );
endinterface

// File: rtl/fifo_writectrl.sv
// Router input-port write controller: frames upstream packets, steers each one into the
// priority or regular FIFO by its head flit, enforces MAX_LEN and counts protocol errors.
module fifo_writectrl #(
  parameter int DATA_W  = 32,
  parameter int MAX_LEN = 16,
  parameter int ERR_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  fifo_writectrl_if.slave    bus,
  output logic               pkt_active,
  output logic [ERR_W-1:0]   err_cnt
);

  localparam int CNT_W = (MAX_LEN > 2) ? $clog2(MAX_LEN) : 1;

  localparam logic [2:0] CODE_HEAD   = 3'b100;
  localparam logic [2:0] CODE_BODY   = 3'b000;
  localparam logic [2:0] CODE_TAIL   = 3'b110;
  localparam logic [2:0] CODE_SINGLE = 3'b111;

  typedef enum logic [1:0] {IDLE, PKT_REG, PKT_PRI} state_e;
  typedef enum logic [2:0] {K_HEAD, K_BODY, K_TAIL, K_SINGLE, K_INVALID} kind_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ERR_W-1:0]  err_q, err_d;

  kind_e             kind;
  logic              opens;
  logic              drop;
  logic              tgt_pri;
  logic              tgt_full;
  logic              ready;
  logic              accept;
  logic              write;
  logic              truncate;
  logic              err_inc;
  logic [DATA_W-1:0] wdata;

  // NOTE: every combinational output is given a value on every path (default arm or
  // default-first assignment) so no latch is inferred.
  always_comb begin
    case (bus.in_head)
      CODE_HEAD:   kind = K_HEAD;
      CODE_BODY:   kind = K_BODY;
      CODE_TAIL:   kind = K_TAIL;
      CODE_SINGLE: kind = K_SINGLE;
      default:     kind = K_INVALID;
    endcase
  end

  // A HEAD/SINGLE flit always chooses its own FIFO; inside a packet the open packet decides.
  always_comb begin
    opens    = (kind == K_HEAD) || (kind == K_SINGLE);
    drop     = (kind == K_INVALID) || ((state_q == IDLE) && !opens);
    tgt_pri  = ((state_q == IDLE) || opens) ? bus.in_pri : (state_q == PKT_PRI);
    tgt_full = tgt_pri ? bus.priorityFIFO_full : bus.regularFIFO_full;
    ready    = rst_n && (drop || !tgt_full);
    accept   = bus.in_valid && ready;
    write    = accept && !drop;
    truncate = (state_q != IDLE) && (kind == K_BODY) && (cnt_q == CNT_W'(MAX_LEN - 1));
  end

  assign wdata                  = bus.in_data;
  assign bus.in_ready           = ready;
  assign bus.regularFIFO_write  = write && !tgt_pri;
  assign bus.priorityFIFO_write = write && tgt_pri;
  assign bus.fifo_whead         = truncate ? CODE_TAIL : bus.in_head;
  assign bus.fifo_wdata         = wdata;
  assign pkt_active             = (state_q != IDLE);
  assign err_cnt                = err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_inc = 1'b0;
    if (accept) begin
      if (drop) begin
        err_inc = 1'b1;
      end else begin
        case (kind)
          K_HEAD: begin
            err_inc = (state_q != IDLE);
            state_d = tgt_pri ? PKT_PRI : PKT_REG;
            cnt_d   = CNT_W'(1);
          end
          K_SINGLE: begin
            err_inc = (state_q != IDLE);
            state_d = IDLE;
            cnt_d   = '0;
          end
          K_BODY: begin
            // The over-long packet is closed by its last legal flit, written as a TAIL.
            if (truncate) begin
              err_inc = 1'b1;
              state_d = IDLE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
          K_TAIL: begin
            state_d = IDLE;
            cnt_d   = '0;
          end
          default: begin
            state_d = state_q;
          end
        endcase
      end
    end
    err_d = (err_inc && (err_q != '1)) ? err_q + ERR_W'(1) : err_q;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge value of its inputs regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: doc/fifo_writectrl.md
Name: fifo_writectrl

Overview:
- Input-side write controller of a router input port; the filling end of the regular/priority FIFO pair that the port's read controller drains.
- Accepts flits from the upstream link over a valid/ready handshake and steers each packet into the priority or regular FIFO, chosen by the priority bit of its head flit.
- Enforces packet framing and a maximum packet length, drops orphan flits, and counts protocol errors.

Parameters:
- DATA_W, 32, flit payload width excluding the 3-bit type field.
- MAX_LEN, 16, maximum flits per packet including head and tail; range 2..255.
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream flit valid.
- in_head  in  3  flit type: 3'b100 HEAD, 3'b000 BODY, 3'b110 TAIL, 3'b111 SINGLE (head+tail); other codes are INVALID.
- in_pri  in  1  priority request; sampled only on HEAD/SINGLE flits.
- in_data  in  DATA_W  flit payload.
- in_ready  out  1  flit accepted this cycle when in_valid & in_ready.
- regularFIFO_full  in  1  regular FIFO full.
- priorityFIFO_full  in  1  priority FIFO full.
- regularFIFO_write  out  1  write strobe, regular FIFO.
- priorityFIFO_write  out  1  write strobe, priority FIFO.
- fifo_whead  out  3  flit type written; shared by both FIFOs.
- fifo_wdata  out  DATA_W  payload written; shared by both FIFOs.
- pkt_active  out  1  a packet is open (state not IDLE).
- err_cnt  out  ERR_W  saturating protocol-error count.

Behaviour:
- FSM states: IDLE, PKT_REG, PKT_PRI. Reset: state=IDLE, flit_cnt=0, err_cnt=0.
- Write strobes, in_ready, fifo_whead and fifo_wdata are combinational from registered state and inputs. Under reset: strobes=0, in_ready=0, pkt_active=0.
- Target FIFO:
  - In IDLE, or when the flit is HEAD/SINGLE: target = in_pri ? priority : regular.
  - In PKT_REG: target = regular. In PKT_PRI: target = priority.
- in_ready = 1 when the flit will be dropped; otherwise in_ready = !target_full.
- Write: target strobe = in_valid & in_ready & !drop. fifo_wdata = in_data. fifo_whead = in_head, except on forced truncation where it is 3'b110. Exactly one strobe high at most.
- IDLE transitions:
  - HEAD accepted -> PKT_PRI/PKT_REG per in_pri; flit_cnt=1.
  - SINGLE accepted -> stay IDLE.
  - BODY, TAIL or INVALID -> drop (in_ready=1, no write), err_cnt+1.
- PKT_x transitions:
  - BODY accepted -> flit_cnt+1.
  - TAIL accepted -> IDLE; flit_cnt=0.
  - INVALID -> drop, err_cnt+1, state unchanged.
  - HEAD or SINGLE -> err_cnt+1. The flit is written to its own target. HEAD reopens per its in_pri with flit_cnt=1; SINGLE -> IDLE. The truncated old packet is not repaired.
- Length limit: in PKT_x with flit_cnt==MAX_LEN-1, an accepted BODY is written with fifo_whead forced to 3'b110. Then state -> IDLE and err_cnt+1. Later orphan BODY/TAIL flits are dropped as IDLE orphans.
- Stall: target full -> in_ready=0, no state change; the flit is held upstream. A full non-target FIFO never stalls.
- err_cnt saturates at all-ones. Two error events cannot occur in one cycle (one flit per cycle); increment by at most 1.
- pkt_active = (state!=IDLE).
- Reset mid-packet: state returns to IDLE immediately. Subsequent BODY/TAIL flits of that packet are orphans (dropped, counted).

Test Plan:
- Reset, then HEAD(pri=0), BODY x2, TAIL with FIFOs empty -> 4 regularFIFO_write pulses with types 100,000,000,110. priorityFIFO_write never high. pkt_active high from after the HEAD through the TAIL cycle. err_cnt=0.
- HEAD(pri=1) accepted, then priorityFIFO_full=1 for 3 cycles with BODY valid and regularFIFO_full=0 -> in_ready=0 for 3 cycles, no writes. On release the BODY is written to the priority FIFO.
- In IDLE, drive BODY then TAIL then type 3'b011 -> in_ready=1 each cycle, no writes, err_cnt 0->3.
- MAX_LEN=4: HEAD, BODY, BODY, BODY, BODY, TAIL -> 4 writes; the 4th is written with type 110 -> IDLE, err_cnt=1. The 5th BODY and the TAIL are dropped, err_cnt=3.
- PKT_REG open after HEAD(pri=0), then HEAD(pri=1) -> written to the priority FIFO, state PKT_PRI, err_cnt=1. Next: SINGLE(pri=0) -> regular write type 111, state IDLE, err_cnt=2.
- Drive 300 orphan BODY flits with ERR_W=8 -> err_cnt holds at 255. Assert rst_n=0 mid-packet -> err_cnt=0, pkt_active=0, strobes 0 asynchronously.
